// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point multiply/saturate pipeline.
package fxp_pkg;

    localparam int PIPE_DEPTH = 3;
    localparam int SAT_LIM_W  = 128;

    typedef logic [PIPE_DEPTH-1:0] stage_valid_t;
    typedef logic signed [SAT_LIM_W-1:0] sat_lim_t;

    // Largest (want_min=0) or smallest (want_min=1) two's-complement value of width w.
    function automatic sat_lim_t sat_limits(input int unsigned w, input logic want_min);
        sat_lim_t one;
        one = sat_lim_t'(1);
        if (want_min)
            sat_limits = -(one <<< (w - 1));
        else
            sat_limits = (one <<< (w - 1)) - one;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational scale, optional round-half-up and saturation of a full product.
// FXP_ROUND_EN selects rounding; without it the shift truncates toward -inf.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic signed [2*WIDTH-1:0] prod,
    output logic        [WIDTH-1:0]   res,
    output logic                      sat
);

    localparam logic signed [2*WIDTH:0] MAXV = (2*WIDTH+1)'(sat_limits(WIDTH, 1'b0));
    localparam logic signed [2*WIDTH:0] MINV = (2*WIDTH+1)'(sat_limits(WIDTH, 1'b1));

`ifdef FXP_ROUND_EN
    localparam logic signed [2*WIDTH:0] ONE     = (2*WIDTH+1)'(1);
    localparam logic signed [2*WIDTH:0] RND_ADD = (FRAC > 0) ? (ONE <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
`endif

    logic signed [2*WIDTH:0] ext;
    logic signed [2*WIDTH:0] rnd;
    logic signed [2*WIDTH:0] shifted;

    // One guard bit so the rounding add can never wrap.
    assign ext = {prod[2*WIDTH-1], prod};

    always_comb begin
        rnd = ext;
`ifdef FXP_ROUND_EN
        rnd = ext + RND_ADD;
`endif
        shifted = rnd >>> FRAC;
    end

    always_comb begin
        res = shifted[WIDTH-1:0];
        sat = 1'b0;
        if (shifted > MAXV) begin
            res = MAXV[WIDTH-1:0];
            sat = 1'b1;
        end else if (shifted < MINV) begin
            res = MINV[WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_mul_sat.sv
// Three-stage signed fixed-point multiplier with saturation and a sticky saturation counter.
// Rounding is enabled by defining FXP_ROUND_EN (see fxp_round_sat).
module fxp_mul_sat
    import fxp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_sat,
    input  logic             clr_count,
    output logic [CNT_W-1:0] sat_count
);

    stage_valid_t                vld;
    logic signed [WIDTH-1:0]     a1;
    logic signed [WIDTH-1:0]     b1;
    logic signed [2*WIDTH-1:0]   p2;
    logic        [WIDTH-1:0]     rs_res;
    logic                        rs_sat;
    logic                        advance;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe moves as one; it stalls only when S3 holds a result
    // that downstream refuses, so in_ready mirrors that single advance term.
    assign advance   = !vld[PIPE_DEPTH-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld[PIPE_DEPTH-1];

    fxp_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_round_sat (
        .prod (p2),
        .res  (rs_res),
        .sat  (rs_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            a1      <= '0;
            b1      <= '0;
            p2      <= '0;
            out     <= '0;
            out_sat <= 1'b0;
        end else if (advance) begin
            vld     <= {vld[PIPE_DEPTH-2:0], in_valid};
            a1      <= a;
            b1      <= b;
            p2      <= (2*WIDTH)'(a1) * (2*WIDTH)'(b1);
            out     <= rs_res;
            out_sat <= vld[1] & rs_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count <= '0;
        else if (clr_count)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && (sat_count != {CNT_W{1'b1}}))
            sat_count <= sat_count + 1'b1;
    end

endmodule

// File: tb/tb_fxp_mul_sat.sv
// Directed bench for fxp_mul_sat at WIDTH=32, FRAC=16.
module tb_fxp_mul_sat;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        out_sat;
    logic        clr_count;
    logic [15:0] sat_count;

    logic [32:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    fxp_mul_sat #(
        .WIDTH (32),
        .FRAC  (16),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_sat   (out_sat),
        .clr_count (clr_count),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: one operand pair into an idle pipe; reports latency and the result.
    task automatic send_one(input logic [31:0] op_a, input logic [31:0] op_b,
                            output int lat, output logic [31:0] res, output logic sat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        res = out;
        sat = out_sat;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0; a = '0; b = '0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out !== 32'h0) begin n_err++; $display("FAIL reset_out got=%h exp=0", out); end
        n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        n_vec++; if (sat_count !== 16'h0) begin n_err++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [31:0] r; logic s;
        send_one(32'h00018000, 32'h00020000, lat, r, s);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        n_vec++; if (r !== 32'h00030000) begin n_err++; $display("FAIL basic_out got=%h exp=00030000", r); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL basic_sat got=%b exp=0", s); end
    endtask

    task automatic test_sign();
        int lat; logic [31:0] r; logic s;
        send_one(32'hFFFF0000, 32'hFFFF0000, lat, r, s);
        n_vec++; if (r !== 32'h00010000) begin n_err++; $display("FAIL sign_out got=%h exp=00010000", r); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL sign_sat got=%b exp=0", s); end
        // -1.0 * 0.75 = -0.75
        send_one(32'hFFFF0000, 32'h0000C000, lat, r, s);
        n_vec++; if (r !== 32'hFFFF4000) begin n_err++; $display("FAIL sign_mixed_out got=%h exp=ffff4000", r); end
    endtask

    task automatic test_rounding();
        int lat; logic [31:0] r; logic s;
        logic [31:0] exp_pos, exp_neg;
`ifdef FXP_ROUND_EN
        exp_pos = 32'h00000001;
        exp_neg = 32'h00000000;
`else
        exp_pos = 32'h00000000;
        exp_neg = 32'hFFFFFFFF;
`endif
        send_one(32'h00000001, 32'h00008000, lat, r, s);
        n_vec++; if (r !== exp_pos) begin n_err++; $display("FAIL round_half_pos got=%h exp=%h", r, exp_pos); end
        send_one(32'hFFFFFFFF, 32'h00008000, lat, r, s);
        n_vec++; if (r !== exp_neg) begin n_err++; $display("FAIL round_half_neg got=%h exp=%h", r, exp_neg); end
        n_vec++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL round_no_count got=%0d exp=0", sat_count); end
    endtask

    task automatic test_saturation();
        int lat; logic [31:0] r; logic s;
        send_one(32'h7FFF0000, 32'h00020000, lat, r, s);
        n_vec++; if (r !== 32'h7FFFFFFF) begin n_err++; $display("FAIL sat_pos_out got=%h exp=7fffffff", r); end
        n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL sat_pos_flag got=%b exp=1", s); end
        n_vec++; if (sat_count !== 16'd1) begin n_err++; $display("FAIL sat_pos_count got=%0d exp=1", sat_count); end
        send_one(32'h80000000, 32'h00020000, lat, r, s);
        n_vec++; if (r !== 32'h80000000) begin n_err++; $display("FAIL sat_neg_out got=%h exp=80000000", r); end
        n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL sat_neg_flag got=%b exp=1", s); end
        n_vec++; if (sat_count !== 16'd2) begin n_err++; $display("FAIL sat_neg_count got=%0d exp=2", sat_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] av [6] = '{32'h00010000, 32'h00020000, 32'h00030000,
                                32'h00040000, 32'h7FFF0000, 32'h00060000};
        logic [32:0] ev [6] = '{{1'b0, 32'h00020000}, {1'b0, 32'h00040000}, {1'b0, 32'h00060000},
                                {1'b0, 32'h00080000}, {1'b1, 32'h7FFFFFFF}, {1'b0, 32'h000C0000}};
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic        holding = 1'b0;
        logic [32:0] held = '0;
        logic [32:0] exp;
        exp_q.delete();
        while (got < 6 && cyc < 60) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            if (sent < 6) a = av[sent];
            b         = 32'h00020000;
            clr_count = 1'b0;
            #1;
            if (!out_ready) begin
                n_vec++;
                if (in_ready !== (sent < 3)) begin
                    n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (sent < 3));
                end
            end
            if (out_valid && !out_ready) begin
                if (holding) begin
                    n_vec++;
                    if ({out_sat, out} !== held) begin
                        n_err++; $display("FAIL bp_hold got=%h exp=%h", {out_sat, out}, held);
                    end
                end
                held    = {out_sat, out};
                holding = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra got=%h exp=none", {out_sat, out});
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_sat, out} !== exp) begin
                        n_err++; $display("FAIL bp_result idx=%0d got=%h exp=%h", got, {out_sat, out}, exp);
                    end
                end
                if (got == 4) clr_count = 1'b1;
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ev[sent]);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        clr_count = 1'b0;
        n_vec++; if (got != 6) begin n_err++; $display("FAIL bp_count got=%0d exp=6", got); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_left got=%0d exp=0", exp_q.size()); end
        n_vec++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL bp_clr_wins got=%0d exp=0", sat_count); end
    endtask

    task automatic test_reset_midstream();
        int lat; logic [31:0] r; logic s;
        send_one(32'h7FFF0000, 32'h00020000, lat, r, s);
        n_vec++; if (sat_count !== 16'd1) begin n_err++; $display("FAIL mid_pre_count got=%0d exp=1", sat_count); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 32'h7FFF0000; b = 32'h00020000;
        @(negedge clk);
        a = 32'h80000000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_in_flight got=%b exp=1", out_valid); end
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out !== 32'h0) begin n_err++; $display("FAIL mid_out got=%h exp=0", out); end
        n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL mid_out_sat got=%b exp=0", out_sat); end
        n_vec++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL mid_sat_count got=%0d exp=0", sat_count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", i, out_valid); end
        end
        send_one(32'h00018000, 32'h00020000, lat, r, s);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL mid_latency got=%0d exp=3", lat); end
        n_vec++; if (r !== 32'h00030000) begin n_err++; $display("FAIL mid_out_after got=%h exp=00030000", r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fxp_mul_sat.md
# fxp_mul_sat

Pipelined, parametrised signed fixed-point multiplier with rounding, two's-complement saturation and a valid/ready stream interface. It is the successor to the fixed output selector in the IIR multiplication unit. Each coefficient×sample product in the IIR datapath passes through this block, which returns a WIDTH-bit Q(WIDTH-FRAC).FRAC result plus a per-sample saturation flag and a running saturation count.

## Interface
- WIDTH, 32, operand and result width (≥ 4)
- FRAC, 16, fractional bits of operands and result (0 ≤ FRAC < WIDTH)
- CNT_W, 16, width of saturation event counter
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  signed operand, Q format per FRAC
- b  in  WIDTH  signed operand, Q format per FRAC
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out  out  WIDTH  signed saturated result
- out_sat  out  1  result was clamped
- clr_count  in  1  synchronous clear of sat_count
- sat_count  out  CNT_W  number of saturated results delivered, sticky at max

## Operation
- Three stages, each with a valid bit: S1 registers a and b; S2 registers the full 2·WIDTH signed product; S3 registers the shifted, rounded and saturated result together with out_sat.
- Global advance = !v3 || out_ready. When advance is high, all stages shift forward. When advance is low, all stages hold. in_ready = advance, and the input is accepted when in_valid && in_ready.
- Scaling: arithmetic right shift of the product by FRAC. Rounding (see Configuration) adds 2^(FRAC-1) before the shift, using 2·WIDTH+1 bits so the add cannot wrap.
- Saturation after the shift and round:
  - If value > 2^(WIDTH-1)−1, out = 0111…1 and out_sat = 1.
  - If value < −2^(WIDTH-1), out = 1000…0 and out_sat = 1.
  - Otherwise out = value[WIDTH-1:0] and out_sat = 0.
- Counter: on an output handshake (out_valid && out_ready && out_sat), sat_count increments and holds at 2^CNT_W−1. If clr_count is high in the same cycle, the clear wins and sat_count becomes 0.
- out, out_sat and out_valid come directly from S3 registers. There is no combinational path from a or b to any output.

## Timing
- Reset values: in_ready 1, out_valid 0, out 0, out_sat 0, sat_count 0. All stage valid bits and data registers clear to 0.
- Latency: 3 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 result per cycle.
- Backpressure: if out_ready is low while out_valid is high, in_ready is low in the same cycle. At most 3 results are in flight, and none is dropped or duplicated.
- out and out_sat are stable while out_valid && !out_ready.
- Reset asserted mid-stream discards all in-flight data. The first input accepted after release appears 3 cycles later.
- in_valid low with advance high inserts a bubble. Bubbles never count toward sat_count.

## Configuration
- FXP_ROUND_EN defined: round-half-up (add 2^(FRAC-1) before the shift) when FRAC > 0. A round-up can itself trigger saturation.
- FXP_ROUND_EN undefined: truncation toward −∞ (plain arithmetic shift). This mode uses less logic and matches the legacy IIR output path.

## Structure
- Package fxp_pkg holds:
  - sat_limits function returning MAX/MIN for a given width
  - typedef for the stage-valid vector
  - localparam PIPE_DEPTH = 3
- Sub-module fxp_round_sat is combinational: 2·WIDTH product in; WIDTH result and sat flag out; rounding selected by FXP_ROUND_EN. It is instantiated between S2 and S3.
- Top level holds the pipeline registers, the handshake logic and the counter.

## Test plan
All cases use WIDTH=32, FRAC=16.
- Basic: a=0x00018000 (1.5), b=0x00020000 (2.0), out_ready=1. out=0x00030000 and out_sat=0, exactly 3 cycles after accept.
- Positive saturation: a=0x7FFF0000, b=0x00020000. out=0x7FFFFFFF, out_sat=1, sat_count=1. Negative saturation: a=0x80000000, b=0x00020000. out=0x80000000, out_sat=1, sat_count=2.
- Sign: a=b=0xFFFF0000 (−1.0). out=0x00010000 and out_sat=0.
- Rounding: a=0x00000001, b=0x00008000. With FXP_ROUND_EN, out=0x00000001. Without it, out=0x00000000.
- Backpressure: stream 6 inputs, hold out_ready=0 for 5 cycles. in_ready drops after 3 accepts. All 6 results arrive in order with no loss. A 5th saturating result with clr_count pulsed in the same cycle leaves sat_count=0.
- Reset: assert rst while 2 results are in flight. Outputs go to reset values at once, and no stale result appears after release.
